// File: rtl/hls_deadlock_pkg.sv
// rtl/hls_deadlock_pkg.sv - shared types and constants for the deadlock report collector
// Purpose: collector FSM state encoding, counter widths and an index-width helper.
// Ports: none (package).
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int EVT_CNT_W = 16;
  localparam int RUN_W     = 16;

  // Ceiling log2, never smaller than 1 so a single-monitor build still has an index bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// rtl/hls_deadlock_prio_enc.sv - lowest-set-bit priority encoder
// Purpose: report the index of the lowest set bit of the input vector.
// Ports:
//   bits  in  N  request vector
//   idx   out W  index of lowest set bit (0 when no bit is set)
module hls_deadlock_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/hls_deadlock_report_collector.sv
// rtl/hls_deadlock_report_collector.sv - qualifies persistent HLS blocking and reports one record
// Purpose: watch monitor block outputs; after THRESH consecutive blocked cycles
// capture the lowest blocking index, the AXIS block snapshot and a timestamp,
// and present them on a valid/ready report channel.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   block_sigs  in  NUM_MON        per-monitor block flag
//   axis_snap   in  NUM_MON*SIG_W  concatenated AXIS block signals
//   clear       in  1              clears deadlock_flag
//   rpt_valid/rpt_ready            report handshake
//   rpt_idx, rpt_snap, rpt_ts      captured record
//   deadlock_flag  out 1           sticky deadlock seen
//   event_count    out 16          saturating capture count
module hls_deadlock_report_collector
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int SIG_W = 2,
  parameter int THRESH = 16,
  parameter int TS_W = 32,
  parameter logic [TS_W-1:0] TS_INIT = '0,
  localparam int IDX_W = clog2_min1(NUM_MON)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_MON-1:0]       block_sigs,
  input  logic [NUM_MON*SIG_W-1:0] axis_snap,
  input  logic                     clear,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [IDX_W-1:0]         rpt_idx,
  output logic [NUM_MON*SIG_W-1:0] rpt_snap,
  output logic [TS_W-1:0]          rpt_ts,
  output logic                     deadlock_flag,
  output logic [EVT_CNT_W-1:0]     event_count
);

  localparam logic [RUN_W-1:0] THRESH_R = RUN_W'(THRESH);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TS_W-1:0]  ts_q;
  logic [IDX_W-1:0] enc_idx;
  logic             any;
  logic             capture;

  assign any = |block_sigs;

  hls_deadlock_prio_enc #(
    .N(NUM_MON),
    .W(IDX_W)
  ) u_prio_enc (
    .bits(block_sigs),
    .idx (enc_idx)
  );

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          if (THRESH == 1) begin
            capture = 1'b1;
            state_d = REPORT;
          end else begin
            run_d   = RUN_W'(1);
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (!any) begin
          run_d   = '0;
          state_d = IDLE;
        end else if (run_q + RUN_W'(1) == THRESH_R) begin
          capture = 1'b1;
          run_d   = '0;
          state_d = REPORT;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      REPORT: begin
        // Releasing straight to IDLE when the block already cleared avoids a dead HOLD cycle.
        if (rpt_ready) state_d = any ? HOLD : IDLE;
      end
      HOLD: begin
        if (!any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      run_q         <= '0;
      ts_q          <= TS_INIT;
      rpt_idx       <= '0;
      rpt_snap      <= '0;
      rpt_ts        <= '0;
      deadlock_flag <= 1'b0;
      event_count   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ts_q    <= ts_q + TS_W'(1);
      if (capture) begin
        rpt_idx  <= enc_idx;
        rpt_snap <= axis_snap;
        rpt_ts   <= ts_q;
        if (event_count != '1) event_count <= event_count + EVT_CNT_W'(1);
      end
      // Capture outranks a coincident clear so a fresh deadlock is never hidden.
      if (capture) deadlock_flag <= 1'b1;
      else if (clear) deadlock_flag <= 1'b0;
    end
  end

  assign rpt_valid = (state_q == REPORT);

endmodule

// File: tb/tb_hls_deadlock_report_collector.sv
// tb/tb_hls_deadlock_report_collector.sv - self-checking bench for the deadlock report collector
module tb_hls_deadlock_report_collector;

  typedef struct packed {
    logic [1:0]  idx;
    logic [7:0]  snap;
    logic [31:0] ts;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  block_sigs;
  logic [7:0]  axis_snap;
  logic        clear;
  logic        rpt_ready;
  logic        rpt_valid;
  logic [1:0]  rpt_idx;
  logic [7:0]  rpt_snap;
  logic [31:0] rpt_ts;
  logic        deadlock_flag;
  logic [15:0] event_count;

  logic [3:0]  b_block;
  logic [7:0]  b_snap;
  logic        b_clear;
  logic        b_ready;
  logic        b_valid;
  logic [1:0]  b_idx;
  logic [7:0]  b_rsnap;
  logic [31:0] b_ts;
  logic        b_flag;
  logic [15:0] b_count;

  rec_t        exp_q[$];
  rec_t        got_e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] cyc;
  logic [31:0] e;

  always #5 clock = ~clock;

  hls_deadlock_report_collector #(
    .NUM_MON(4), .SIG_W(2), .THRESH(16), .TS_W(32)
  ) dut (
    .clock(clock), .reset(reset), .block_sigs(block_sigs), .axis_snap(axis_snap),
    .clear(clear), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx),
    .rpt_snap(rpt_snap), .rpt_ts(rpt_ts), .deadlock_flag(deadlock_flag),
    .event_count(event_count)
  );

  hls_deadlock_report_collector #(
    .NUM_MON(4), .SIG_W(2), .THRESH(1), .TS_W(32), .TS_INIT(32'hFFFF_FFFE)
  ) dut_t1 (
    .clock(clock), .reset(reset), .block_sigs(b_block), .axis_snap(b_snap),
    .clear(b_clear), .rpt_valid(b_valid), .rpt_ready(b_ready), .rpt_idx(b_idx),
    .rpt_snap(b_rsnap), .rpt_ts(b_ts), .deadlock_flag(b_flag),
    .event_count(b_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_rec(input logic [1:0] idx, input logic [7:0] snap, input logic [31:0] ts);
    rec_t r;
    r.idx  = idx;
    r.snap = snap;
    r.ts   = ts;
    exp_q.push_back(r);
  endtask

  // Timestamp value the DUT will sample on the next edge.
  always @(posedge clock) begin
    if (reset) cyc <= 32'd0;
    else cyc <= cyc + 32'd1;
  end

  // A handshake seen here completes on the next rising edge.
  always @(negedge clock) begin
    if (!reset && rpt_valid && rpt_ready) begin
      check("record_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        got_e = exp_q.pop_front();
        check("rpt_idx", 64'(rpt_idx), 64'(got_e.idx));
        check("rpt_snap", 64'(rpt_snap), 64'(got_e.snap));
        check("rpt_ts", 64'(rpt_ts), 64'(got_e.ts));
      end
    end
  end

  initial begin
    reset = 1'b1; block_sigs = '0; axis_snap = '0; clear = 1'b0; rpt_ready = 1'b0;
    b_block = '0; b_snap = '0; b_clear = 1'b0; b_ready = 1'b1;
    step(3);
    check("rst_valid", 64'(rpt_valid), 64'd0);
    check("rst_idx", 64'(rpt_idx), 64'd0);
    check("rst_snap", 64'(rpt_snap), 64'd0);
    check("rst_ts", 64'(rpt_ts), 64'd0);
    check("rst_flag", 64'(deadlock_flag), 64'd0);
    check("rst_count", 64'(event_count), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    reset = 1'b0;

    // THRESH=1 instance: one blocked cycle -> record next cycle; timestamp wrap.
    b_block = 4'b0001; b_snap = 8'h02;
    step(1);
    check("t1_valid", 64'(b_valid), 64'd1);
    check("t1_idx", 64'(b_idx), 64'd0);
    check("t1_snap", 64'(b_rsnap), 64'h02);
    check("t1_ts", 64'(b_ts), 64'hFFFF_FFFE);
    b_block = 4'b0000;
    step(1);
    check("t1_released", 64'(b_valid), 64'd0);
    b_block = 4'b0100; b_snap = 8'h40;
    step(1);
    check("wrap_valid", 64'(b_valid), 64'd1);
    check("wrap_idx", 64'(b_idx), 64'd2);
    check("wrap_ts", 64'(b_ts), 64'd0);
    check("wrap_count", 64'(b_count), 64'd2);
    b_block = 4'b0000;
    step(1);

    // Qualify after 16 consecutive blocked cycles.
    rpt_ready = 1'b1; block_sigs = 4'b0100; axis_snap = 8'h30; e = cyc;
    expect_rec(2'd2, 8'h30, e + 32'd15);
    step(15);
    check("q_not_yet", 64'(rpt_valid), 64'd0);
    step(1);
    check("q_valid", 64'(rpt_valid), 64'd1);
    check("q_flag", 64'(deadlock_flag), 64'd1);
    check("q_count", 64'(event_count), 64'd1);
    block_sigs = 4'b0000; axis_snap = 8'h00;
    step(1);
    check("q_released", 64'(rpt_valid), 64'd0);
    step(1);

    // Glitch reject: 15 blocked, 1 clear, 15 blocked.
    for (int i = 0; i < 33; i++) begin
      block_sigs = (i == 15 || i >= 31) ? 4'b0000 : 4'b0001;
      step(1);
      check("g_valid", 64'(rpt_valid), 64'd0);
    end
    check("g_count", 64'(event_count), 64'd1);

    // Backpressure with toggling block inputs.
    rpt_ready = 1'b0; block_sigs = 4'b0010; axis_snap = 8'h5A; e = cyc;
    expect_rec(2'd1, 8'h5A, e + 32'd15);
    step(16);
    check("bp_valid", 64'(rpt_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      block_sigs = i[0] ? 4'b1111 : 4'b0001;
      axis_snap = 8'($urandom);
      step(1);
      check("bp_hold_valid", 64'(rpt_valid), 64'd1);
      check("bp_hold_idx", 64'(rpt_idx), 64'd1);
      check("bp_hold_snap", 64'(rpt_snap), 64'h5A);
      check("bp_hold_ts", 64'(rpt_ts), 64'(e + 32'd15));
    end
    block_sigs = 4'b0100; rpt_ready = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_no_second", 64'(rpt_valid), 64'd0);
    end
    check("bp_count", 64'(event_count), 64'd2);
    block_sigs = 4'b0000;
    step(2);

    // Priority and re-arm.
    block_sigs = 4'b1010; axis_snap = 8'hC3; e = cyc;
    expect_rec(2'd1, 8'hC3, e + 32'd15);
    step(16);
    check("p1_valid", 64'(rpt_valid), 64'd1);
    block_sigs = 4'b0000;
    step(1);
    check("p1_released", 64'(rpt_valid), 64'd0);
    block_sigs = 4'b1000; axis_snap = 8'h81; e = cyc;
    expect_rec(2'd3, 8'h81, e + 32'd15);
    step(16);
    check("p2_valid", 64'(rpt_valid), 64'd1);
    block_sigs = 4'b0000;
    step(1);
    check("p2_count", 64'(event_count), 64'd4);

    // Clear, then clear colliding with capture.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("c_flag_cleared", 64'(deadlock_flag), 64'd0);
    check("c_count_kept", 64'(event_count), 64'd4);
    rpt_ready = 1'b0; block_sigs = 4'b0001; axis_snap = 8'h11; e = cyc;
    expect_rec(2'd0, 8'h11, e + 32'd15);
    step(15);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("c_collide_flag", 64'(deadlock_flag), 64'd1);
    check("c_collide_valid", 64'(rpt_valid), 64'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("c_late_flag", 64'(deadlock_flag), 64'd0);
    check("c_late_count", 64'(event_count), 64'd5);
    check("c_late_valid", 64'(rpt_valid), 64'd1);
    rpt_ready = 1'b1; block_sigs = 4'b0000;
    step(1);
    check("c_released", 64'(rpt_valid), 64'd0);

    // Reset while a record is pending drops it.
    rpt_ready = 1'b0; block_sigs = 4'b0100; axis_snap = 8'h77;
    step(16);
    check("r_valid", 64'(rpt_valid), 64'd1);
    reset = 1'b1; block_sigs = 4'b0000;
    step(1);
    check("r_valid0", 64'(rpt_valid), 64'd0);
    check("r_idx0", 64'(rpt_idx), 64'd0);
    check("r_snap0", 64'(rpt_snap), 64'd0);
    check("r_ts0", 64'(rpt_ts), 64'd0);
    check("r_flag0", 64'(deadlock_flag), 64'd0);
    check("r_count0", 64'(event_count), 64'd0);
    reset = 1'b0; rpt_ready = 1'b1;
    step(2);
    check("r_after", 64'(rpt_valid), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_report_collector.md
Name: hls_deadlock_report_collector

Overview:
- Consumer end of the per-instance HLS deadlock monitors. Takes their `block` outputs and AXIS block snapshots.
- Qualifies a deadlock only when blocking persists for THRESH consecutive cycles.
- Captures a diagnostic record: first offending monitor index, snapshot, timestamp. Emits it on a valid/ready report channel.
- Sits at top level beside the monitor tree and feeds debug logic or a host-readable FIFO.

Parameters:
- NUM_MON, 4, number of monitor `block` inputs.
- SIG_W, 2, AXIS block signals per monitor in the snapshot.
- THRESH, 16, consecutive blocked cycles required to qualify; legal range 1..65535.
- TS_W, 32, timestamp counter width.
- IDX_W, clog2(NUM_MON) (min 1), width of the reported index; derived, not overridable.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- block_sigs  in  NUM_MON  `block` output of each monitor.
- axis_snap  in  NUM_MON*SIG_W  concatenated axis_block_sigs of all monitors.
- clear  in  1  one-cycle pulse; clears deadlock_flag.
- rpt_valid  out  1  report record available.
- rpt_ready  in  1  report consumer accepts.
- rpt_idx  out  IDX_W  lowest-index monitor blocking at capture.
- rpt_snap  out  NUM_MON*SIG_W  axis_snap at capture.
- rpt_ts  out  TS_W  timestamp at capture.
- deadlock_flag  out  1  sticky "deadlock seen".
- event_count  out  16  saturating count of captured deadlocks.

Behaviour:

Reset values
- Synchronous, active-high.
- All outputs 0, state IDLE, run counter 0, timestamp 0.

Core signals
- `any` = OR of block_sigs.
- Timestamp: free-running counter, +1 every non-reset cycle, wraps 2^TS_W-1 -> 0.

States: IDLE, ARMED, REPORT, HOLD.
- IDLE:
  - any=1 and THRESH=1 -> capture, go to REPORT.
  - any=1 and THRESH>1 -> run=1, go to ARMED.
- ARMED:
  - any=0 -> run=0, go to IDLE.
  - else run+1; when the incremented run equals THRESH -> capture, go to REPORT.
  - The run counter is 16 bits and never exceeds THRESH.
- Capture, all values registered from the same sampled edge:
  - rpt_idx = lowest set bit of block_sigs.
  - rpt_snap = axis_snap.
  - rpt_ts = current timestamp.
  - deadlock_flag <= 1.
  - event_count +1, saturating at 0xFFFF.
- Capture latency: if block_sigs is non-zero on edges k..k+THRESH-1, rpt_valid is high in the cycle after edge k+THRESH-1.
- REPORT:
  - rpt_valid=1; payload held stable until rpt_valid&rpt_ready.
  - Handshake -> HOLD.
  - rpt_valid never deasserts without a handshake, except on reset.
- HOLD:
  - Waits for any=0 on one sampled edge, then goes to IDLE and re-arms.
  - A continuously blocked design produces exactly one record.
  - If any=0 in the same cycle as the handshake, go straight to IDLE.
- clear:
  - Clears deadlock_flag on the next edge in any state.
  - Does not affect state, the record, or event_count.
  - clear coincident with capture: capture wins, flag ends at 1.
- Intermittent block: a gap of one cycle (any=0) restarts the run from 0; the next block starts at run=1.
- block_sigs changing during REPORT/HOLD: ignored for the payload.
- Reset mid-REPORT: the record is dropped; rpt_valid is 0 in the cycle after the reset edge.
- No combinational path from any input to any output.

Decomposition:
- Shared package `hls_deadlock_pkg`:
  - state enum (IDLE, ARMED, REPORT, HOLD);
  - EVT_CNT_W=16 and RUN_W=16 constants;
  - clog2 helper for IDX_W.
- One natural sub-module: `hls_deadlock_prio_enc`, a lowest-set-bit priority encoder, NUM_MON -> IDX_W, combinational.
- FSM, counters and report register stay in the top module.

Test Plan:
- Qualify: THRESH=16, block_sigs=4'b0100, axis_snap=8'h30 from edge 10 onward, rpt_ready=1 -> rpt_valid high one cycle after edge 25 with rpt_idx=2, rpt_snap=8'h30, rpt_ts=25; deadlock_flag=1; event_count=1.
- Glitch reject: block_sigs=4'b0001 for 15 cycles, 0 for one cycle, then 15 more -> no rpt_valid; event_count=0.
- Backpressure: capture with rpt_ready=0 for 20 cycles while block_sigs toggles -> rpt_valid stays 1, payload unchanged; ready=1 completes one handshake; no second record while block remains high.
- Priority and re-arm: block_sigs=4'b1010 to capture -> rpt_idx=1; drop to 0 after the handshake, then 4'b1000 for 16 cycles -> second record with rpt_idx=3; event_count=2.
- Clear/capture collision: clear pulsed on the capture edge -> deadlock_flag=1; clear one cycle later -> flag=0, event_count unchanged.
- Edge cases:
  - THRESH=1: a single blocked cycle produces a record one cycle later.
  - Reset asserted during REPORT: all outputs 0 next cycle.
  - Timestamp wraps from 0xFFFFFFFF to 0, forced via init.
